uc_multiciclo: RTL

//  Multi-cycle control unit that sequences Instruction_FD (RV64 subset: ld, sd, R-type add/sub,

---
 rtl/uc_multiciclo.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for the Instruction_FD datapath (RV64 subset).
// Moore outputs decoded from the registered state and the decode fields
// latched in DECODE; adds run/idle handshake, illegal-opcode halt and a
// retired-instruction counter.
module uc_multiciclo #(
    parameter int unsigned RET_W        = 32,
    parameter bit          ILLEGAL_HALT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      instr,
    output logic             WE_mem,
    output logic             WE_reg,
    output logic [1:0]       OP_MEM_I,
    output logic             ADD_SUB,
    output logic             PC_load,
    output logic             IR_load,
    output logic             JAL,
    output logic             JALR,
    output logic             AUIPC,
    output logic [2:0]       select_flags,
    output logic             busy,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEMWB  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_SD    = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] NEVER_BRANCH = 3'b010;

    logic [2:0] state, state_nxt;
    logic [6:0] opcode_q;
    logic [2:0] funct3_q;
    logic       f7b5_q;
    logic       exec_legal;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        case (op)
            OPC_LD, OPC_SD:               ok = (f3 == 3'b011);
            OPC_OP, OPC_OPIMM, OPC_JALR:  ok = (f3 == 3'b000);
            OPC_BR:                       ok = (f3 != 3'b010) && (f3 != 3'b011);
            OPC_JAL, OPC_AUIPC:           ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign exec_legal = is_legal(opcode_q, funct3_q);

    // Moore output decode from state and latched instruction fields
    always_comb begin
        WE_mem       = 1'b0;
        WE_reg       = 1'b0;
        OP_MEM_I     = 2'b00;
        ADD_SUB      = 1'b0;
        PC_load      = 1'b0;
        IR_load      = 1'b0;
        JAL          = 1'b0;
        JALR         = 1'b0;
        AUIPC        = 1'b0;
        select_flags = NEVER_BRANCH;
        case (state)
            S_FETCH: IR_load = 1'b1;
            S_EXEC: begin
                if (!exec_legal) begin
                    PC_load = 1'b1;
                end else begin
                    case (opcode_q)
                        OPC_LD: OP_MEM_I = 2'b01;
                        OPC_SD: begin
                            OP_MEM_I = 2'b01;
                            WE_mem   = 1'b1;
                            PC_load  = 1'b1;
                        end
                        OPC_OP: begin
                            WE_reg  = 1'b1;
                            ADD_SUB = f7b5_q;
                            PC_load = 1'b1;
                        end
                        OPC_OPIMM: begin
                            OP_MEM_I = 2'b10;
                            WE_reg   = 1'b1;
                            PC_load  = 1'b1;
                        end
                        OPC_BR: begin
                            ADD_SUB      = 1'b1;
                            select_flags = funct3_q;
                            PC_load      = 1'b1;
                        end
                        OPC_JAL: begin
                            OP_MEM_I = 2'b11;
                            JAL      = 1'b1;
                            WE_reg   = 1'b1;
                            PC_load  = 1'b1;
                        end
                        OPC_JALR: begin
                            OP_MEM_I = 2'b11;
                            JALR     = 1'b1;
                            WE_reg   = 1'b1;
                            PC_load  = 1'b1;
                        end
                        OPC_AUIPC: begin
                            OP_MEM_I = 2'b11;
                            AUIPC    = 1'b1;
                            WE_reg   = 1'b1;
                            PC_load  = 1'b1;
                        end
                        default: PC_load = 1'b1;
                    endcase
                end
            end
            S_MEMWB: begin
                OP_MEM_I = 2'b01;
                WE_reg   = 1'b1;
                PC_load  = 1'b1;
            end
            default: ;
        endcase
        busy   = (state != S_IDLE) && (state != S_HALT);
        halted = (state == S_HALT);
    end

    // Next-state logic; any PC_load cycle ends the instruction
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_legal(instr[6:0], instr[14:12]) || !ILLEGAL_HALT)
                    state_nxt = S_EXEC;
                else
                    state_nxt = S_HALT;
            end
            S_EXEC, S_MEMWB: begin
                if (PC_load)
                    state_nxt = run ? S_FETCH : S_IDLE;
                else
                    state_nxt = S_MEMWB;
            end
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State, decode-field latch and retired counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            retired  <= '0;
            opcode_q <= '0;
            funct3_q <= '0;
            f7b5_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (PC_load)
                retired <= retired + RET_W'(1);
            if (state == S_DECODE) begin
                opcode_q <= instr[6:0];
                funct3_q <= instr[14:12];
                f7b5_q   <= instr[30];
            end
        end
    end

endmodule
